image_loader: RTL and testbench

IMAGE_LOADER -- requirements
Module: image_loader

---
 rtl/bnn_pkg.sv | 14 +
 rtl/image_loader.sv | 85 ++++++++
 tb/tb_image_loader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared constants and loader state type for the BNN image path.
package bnn_pkg;

  localparam int unsigned NUM_PIX_DEF   = 784;
  localparam int unsigned BEAT_W_DEF    = 8;
  localparam int unsigned BEATS_PER_IMG = NUM_PIX_DEF / BEAT_W_DEF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StFull = 2'd2
  } loader_state_e;

endpackage

// File: rtl/image_loader.sv
// Assembles a binarized image from fixed-width pixel beats and holds it until acknowledged.
module image_loader
  import bnn_pkg::*;
#(
  parameter int unsigned BEAT_W  = BEAT_W_DEF,
  parameter int unsigned NUM_PIX = NUM_PIX_DEF,
  localparam int unsigned Beats  = NUM_PIX / BEAT_W,
  localparam int unsigned CntW   = (Beats > 1) ? $clog2(Beats) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sof,
  input  logic [BEAT_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NUM_PIX-1:0] pixels,
  output logic               img_valid,
  input  logic               img_ack,
  output logic [CntW-1:0]    beat_cnt
);

  loader_state_e      state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUM_PIX-1:0] pix_q, pix_d;
  logic [CntW-1:0]    wr_idx;
  logic               accept;

  // Outputs depend on state alone; the full image is flagged while parked in StFull.
  always_comb begin
    in_ready  = (state_q != StFull);
    img_valid = (state_q == StFull);
    pixels    = pix_q;
    beat_cnt  = cnt_q;
  end

  // Next-state, beat counter and pixel write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    accept  = in_valid && in_ready;
    // sof restarts the frame, so a beat arriving with it lands in slot 0.
    wr_idx  = sof ? '0 : cnt_q;
    unique case (state_q)
      StIdle, StLoad: begin
        if (accept) begin
          pix_d[int'(wr_idx) * BEAT_W +: BEAT_W] = in_data;
          if (wr_idx == CntW'(Beats - 1)) begin
            state_d = StFull;
            cnt_d   = '0;
          end else begin
            state_d = StLoad;
            cnt_d   = wr_idx + CntW'(1);
          end
        end else if (sof) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StFull: begin
        if (img_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and image registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Directed plus randomized bench for image_loader against a byte-array frame model.
module tb_image_loader;

  localparam int NB = 98;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sof = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [783:0] pixels;
  logic         img_valid;
  logic         img_ack = 1'b0;
  logic [6:0]   beat_cnt;

  int total = 0;
  int bad = 0;

  // Reference model: image bytes, accepted-beat count, image-complete flag.
  logic [7:0] m_img [NB];
  int         m_cnt = 0;
  bit         m_full = 1'b0;

  image_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sof      (sof),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pixels   (pixels),
    .img_valid(img_valid),
    .img_ack  (img_ack),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [783:0] model_pixels();
    logic [783:0] v;
    for (int i = 0; i < NB; i++) v[i*8 +: 8] = m_img[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [783:0] obs, input logic [783:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 784'(in_ready), 784'(!m_full));
    chk("img_valid", 784'(img_valid), 784'(m_full));
    chk("beat_cnt", 784'(beat_cnt), 784'(m_cnt));
    chk("pixels", pixels, model_pixels());
  endtask

  // One clock: drive inputs, advance the model by the frame rules, then compare.
  task automatic cyc(input bit r, input bit s, input bit v, input bit a, input logic [7:0] d);
    int idx;
    rst_n = !r; sof = s; in_valid = v; img_ack = a; in_data = d;
    @(posedge clk);
    if (r) begin
      m_full = 1'b0; m_cnt = 0;
      for (int i = 0; i < NB; i++) m_img[i] = 8'h00;
    end else if (m_full) begin
      if (a) m_full = 1'b0;
    end else if (v) begin
      idx = s ? 0 : m_cnt;
      m_img[idx] = d;
      m_cnt = idx + 1;
      if (m_cnt == NB) begin
        m_full = 1'b1;
        m_cnt = 0;
      end
    end else if (s) begin
      m_cnt = 0;
    end
    #1;
    check_all();
  endtask

  initial begin
    int acc;
    int guard;
    logic [7:0] r8;
    for (int i = 0; i < NB; i++) m_img[i] = 8'h00;

    // Reset held three cycles with a valid beat pending: nothing may be written.
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 8'hFF);
    cyc(0, 0, 0, 0, 8'h00);
    chk("reset_pixels_zero", pixels, 784'd0);

    // Full frame, beat k = k.
    for (int k = 0; k < NB; k++) cyc(0, 0, 1, 0, 8'(k));
    chk("frame_valid", 784'(img_valid), 784'd1);
    chk("frame_first_byte", 784'(pixels[7:0]), 784'h00);
    chk("frame_last_byte", 784'(pixels[783:776]), 784'h61);

    // Backpressure while full, sof ignored in full, then acknowledge.
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 8'hFF);
    cyc(0, 1, 1, 0, 8'hEE);
    chk("full_last_byte_held", 784'(pixels[783:776]), 784'h61);
    cyc(0, 0, 0, 1, 8'h00);
    chk("ack_ready", 784'(in_ready), 784'd1);
    cyc(0, 0, 0, 1, 8'h00);  // ack outside full is ignored

    // sof without a beat, then restart mid-frame with a beat on sof.
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 8'hAA);
    cyc(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 40; i++) cyc(0, 0, 1, 0, 8'hAA);
    cyc(0, 1, 1, 0, 8'h55);
    for (int i = 0; i < 97; i++) cyc(0, 0, 1, 0, 8'h0F);
    chk("sof_first_byte", 784'(pixels[7:0]), 784'h55);
    chk("sof_byte1", 784'(pixels[15:8]), 784'h0F);
    chk("sof_valid", 784'(img_valid), 784'd1);
    cyc(0, 0, 0, 1, 8'h00);

    // Random gaps and random data; stray acks while loading must do nothing.
    acc = 0;
    guard = 0;
    while (acc < NB && guard < 2000) begin
      r8 = 8'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        cyc(0, 0, 1, 1'($urandom_range(1, 0)), r8);
        acc++;
      end else begin
        cyc(0, 0, 0, 1'($urandom_range(1, 0)), r8);
      end
      guard++;
    end
    chk("gap_budget", 784'(acc), 784'(NB));
    chk("gap_valid", 784'(img_valid), 784'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00);  // stall in full holds
    cyc(0, 0, 0, 1, 8'h00);

    // Reset mid-frame discards everything.
    for (int i = 0; i < 50; i++) cyc(0, 0, 1, 0, 8'($urandom));
    cyc(1, 0, 1, 0, 8'h3C);
    chk("midreset_cnt", 784'(beat_cnt), 784'd0);
    chk("midreset_pixels", pixels, 784'd0);
    for (int i = 0; i < 97; i++) cyc(0, 0, 1, 0, 8'($urandom));
    chk("midreset_not_yet", 784'(img_valid), 784'd0);
    cyc(0, 0, 1, 0, 8'hC3);
    chk("midreset_valid", 784'(img_valid), 784'd1);
    chk("midreset_last_byte", 784'(pixels[783:776]), 784'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
